// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor, one bit per clock LSB first,
// with valid/ready handshakes on operands and result.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] opa_sr, opb_sr, res_sr, res_nx;
    logic [CNT_W-1:0] cnt;
    logic             cf, cf_nx, bit_s, last;

    always_comb begin
        bit_s    = opa_sr[0] ^ opb_sr[0] ^ cf;
        cf_nx    = (opa_sr[0] & opb_sr[0]) | (opa_sr[0] & cf) | (opb_sr[0] & cf);
        res_nx   = res_sr >> 1;
        res_nx[WIDTH-1] = bit_s;
        last     = cnt == CNT_W'(WIDTH - 1);
        state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) :
                                   (out_ready ? IDLE : DONE);
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            opa_sr   <= '0;
            opb_sr   <= '0;
            res_sr   <= '0;
            cf       <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                opa_sr <= a;
                opb_sr <= sub ? ~b : b;
                cf     <= sub | ci;
                cnt    <= '0;
            end else if (state == RUN) begin
                opa_sr <= opa_sr >> 1;
                opb_sr <= opb_sr >> 1;
                res_sr <= res_nx;
                cf     <= cf_nx;
                cnt    <= last ? cnt : cnt + CNT_W'(1);
                // old cf is the carry into the MSB on the final bit
                if (last) begin
                    sum      <= res_nx;
                    carry    <= cf_nx;
                    overflow <= cf ^ cf_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed checks of serial_adder at WIDTH 8, 4 and 1
// against an arithmetic reference model.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic       in_valid8 = 0, in_ready8, ci8 = 0, sub8 = 0, out_valid8, out_ready8 = 0, carry8, ovf8;
    logic [7:0] a8 = 0, b8 = 0, sum8;
    logic       in_valid4 = 0, in_ready4, ci4 = 0, sub4 = 0, out_valid4, out_ready4 = 0, carry4, ovf4;
    logic [3:0] a4 = 0, b4 = 0, sum4;
    logic       in_valid1 = 0, in_ready1, ci1 = 0, sub1 = 0, out_valid1, out_ready1 = 0, carry1, ovf1;
    logic [0:0] a1 = 0, b1 = 0, sum1;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .ci(ci8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .carry(carry8), .overflow(ovf8));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .ci(ci4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .carry(carry4), .overflow(ovf4));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .ci(ci1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .carry(carry1), .overflow(ovf1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // returns {overflow, carry, sum}; overflow from operand/result signs
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input logic sub);
        logic [64:0] m, bb, t;
        logic [63:0] s;
        m  = (65'd1 << w) - 65'd1;
        bb = sub ? (~{1'b0, b}) & m : {1'b0, b} & m;
        t  = {1'b0, a} + bb + (sub ? 65'd1 : {64'd0, ci});
        s  = t[63:0] & m[63:0];
        return {(a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]), t[w], s};
    endfunction

    task automatic wait_out8(output int n);
        n = 0;
        while (!out_valid8 && n < 100) begin @(posedge clk); #1; n++; end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub, input int stall);
        logic [65:0] e;
        int n;
        e = model(8, {56'd0, a}, {56'd0, b}, ci, sub);
        a8 = a; b8 = b; ci8 = ci; sub8 = sub; in_valid8 = 1;
        n = 0;
        while (!in_ready8 && n < 50) begin @(posedge clk); #1; n++; end
        chk("accept8", {63'd0, in_ready8}, 64'd1);
        @(posedge clk); #1;
        in_valid8 = 0;
        wait_out8(n);
        chk("lat8", 64'(n), 64'd8);
        chk("res8", {54'd0, ovf8, carry8, sum8}, {54'd0, e[65], e[64], e[7:0]});
        repeat (stall) begin
            @(posedge clk); #1;
            chk("hold8", {52'd0, out_valid8, in_ready8, ovf8, carry8, sum8}, {52'd0, 2'b10, e[65], e[64], e[7:0]});
        end
        out_ready8 = 1;
        @(posedge clk); #1;
        out_ready8 = 0;
        chk("hs8", {62'd0, out_valid8, in_ready8}, 64'd1);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic sub, input int stall);
        logic [65:0] e;
        int n;
        e = model(4, {60'd0, a}, {60'd0, b}, ci, sub);
        a4 = a; b4 = b; ci4 = ci; sub4 = sub; in_valid4 = 1;
        n = 0;
        while (!in_ready4 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid4 = 0;
        n = 0;
        while (!out_valid4 && n < 100) begin @(posedge clk); #1; n++; end
        chk("lat4", 64'(n), 64'd4);
        repeat (stall) begin @(posedge clk); #1; end
        chk("res4", {58'd0, out_valid4, ovf4, carry4, sum4}, {58'd0, 1'b1, e[65], e[64], e[3:0]});
        out_ready4 = 1;
        @(posedge clk); #1;
        out_ready4 = 0;
    endtask

    task automatic run1(input logic a, input logic b, input logic ci, input logic sub, input int stall);
        logic [65:0] e;
        int n;
        e = model(1, {63'd0, a}, {63'd0, b}, ci, sub);
        a1 = a; b1 = b; ci1 = ci; sub1 = sub; in_valid1 = 1;
        n = 0;
        while (!in_ready1 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid1 = 0;
        n = 0;
        while (!out_valid1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("lat1", 64'(n), 64'd1);
        repeat (stall) begin @(posedge clk); #1; end
        chk("res1", {61'd0, ovf1, carry1, sum1}, {61'd0, e[65], e[64], e[0]});
        out_ready1 = 1;
        @(posedge clk); #1;
        out_ready1 = 0;
        chk("hs1", {62'd0, out_valid1, in_ready1}, 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [65:0] e;
        int n;
        #12;
        chk("rst8", {53'd0, out_valid8, in_ready8, ovf8, carry8, sum8}, {53'd0, 2'b01, 10'd0});
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        run8(8'hFF, 8'h01, 0, 0, 0);
        chk("ff01", {54'd0, ovf8, carry8, sum8}, {54'd0, 2'b01, 8'h00});
        run8(8'h7F, 8'h01, 0, 0, 1);
        chk("7f01", {54'd0, ovf8, carry8, sum8}, {54'd0, 2'b10, 8'h80});
        run8(8'h05, 8'h07, 1, 1, 2);
        chk("0507s", {54'd0, ovf8, carry8, sum8}, {54'd0, 2'b00, 8'hFE});
        run8(8'h80, 8'h01, 0, 1, 0);
        chk("8001s", {54'd0, ovf8, carry8, sum8}, {54'd0, 2'b11, 8'h7F});

        // backpressure with new operands offered while the result is held
        e = model(8, 64'h12, 64'h34, 1'b0, 1'b0);
        a8 = 8'h12; b8 = 8'h34; ci8 = 0; sub8 = 0; in_valid8 = 1;
        @(posedge clk); #1;
        a8 = 8'h55; b8 = 8'h0F; ci8 = 1; sub8 = 1;
        wait_out8(n);
        chk("bp_lat", 64'(n), 64'd8);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold", {52'd0, out_valid8, in_ready8, ovf8, carry8, sum8}, {52'd0, 2'b10, e[65], e[64], e[7:0]});
        end
        out_ready8 = 1;
        @(posedge clk); #1;
        out_ready8 = 0;
        chk("bp_hs", {62'd0, out_valid8, in_ready8}, 64'd1);
        @(posedge clk); #1;
        in_valid8 = 0;
        chk("bp_acc", {63'd0, in_ready8}, 64'd0);
        e = model(8, 64'h55, 64'h0F, 1'b1, 1'b1);
        wait_out8(n);
        chk("bp_lat2", 64'(n), 64'd8);
        chk("bp_res", {54'd0, ovf8, carry8, sum8}, {54'd0, e[65], e[64], e[7:0]});
        out_ready8 = 1;
        @(posedge clk); #1;
        out_ready8 = 0;

        // abort mid-RUN with asynchronous reset
        a8 = 8'hA5; b8 = 8'h3C; ci8 = 0; sub8 = 0; in_valid8 = 1;
        @(posedge clk); #1;
        in_valid8 = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("abort", {53'd0, out_valid8, in_ready8, ovf8, carry8, sum8}, {53'd0, 2'b01, 10'd0});
        @(posedge clk); #1;
        rst_n = 1;
        n = 0;
        repeat (12) begin @(posedge clk); #1; n += int'(out_valid8); end
        chk("no_ov", 64'(n), 64'd0);
        run8(8'h03, 8'h04, 1, 0, 0);
        chk("after_rst", {54'd0, ovf8, carry8, sum8}, {54'd0, 2'b00, 8'h08});

        for (int i = 0; i < 150; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        for (int i = 0; i < 1024; i++)
            run4(i[3:0], i[7:4], i[8], i[9], int'($urandom_range(0, 3)));

        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 16; i++)
                run1(i[0], i[1], i[2], i[3], int'($urandom_range(0, 2)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
